// File: rtl/pipe_hold_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hold_ctrl
//
// Pipeline hold/flush controller. It produces the hold and flush controls for
// the inter-stage registers (PC, IF/ID, ID/EX, EX/MEM) and the single PC
// redirect strobe.
//
// Priority each cycle:
//   memory stall > EX stall > jump (pending or new) > ID load-use.
//
// If EX resolves a jump while memory is stalling, the target is remembered.
// It is replayed in the first cycle in which neither stall is requested.
//
// Outputs are combinational from the current state and inputs. All outputs are
// forced to 0 while Rst is low.
//
// Parameters:
//   ADDR_WIDTH   width of the jump target address
//   FLUSH_EXTRA  extra cycles (0..7) IF/ID stays flushed after a redirect
//
// Ports:
//   Clk, Rst            clock, asynchronous active-low reset
//   JumpFlagFromEx      EX resolved a taken branch/jump this cycle
//   JumpAddrFromEx      redirect target from EX
//   StallReqFromEx      multi-cycle EX operation busy
//   StallReqFromMem     data memory not ready
//   LoadUseFromId       ID source depends on a load currently in EX
//   HoldPc/HoldIf2Id/HoldId2Ex/HoldEx2Mem   1 = register keeps its value
//   FlushIf2Id/FlushId2Ex                  1 = register loads a bubble
//   JumpFlagToPc        one-cycle redirect strobe
//   JumpAddrToPc        redirect target, 0 when JumpFlagToPc is 0
//
// Optional feature (macro PIPE_HOLD_CTRL_PERF_EN):
//   StallCycleCnt       counts cycles with HoldPc = 1 (wraps at 2^32)
//   RedirectCnt         counts cycles with JumpFlagToPc = 1 (wraps at 2^32)
// -----------------------------------------------------------------------------
module pipe_hold_ctrl #(
    parameter int ADDR_WIDTH  = 64,
    parameter int FLUSH_EXTRA = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  JumpFlagFromEx,
    input  logic [ADDR_WIDTH-1:0] JumpAddrFromEx,
    input  logic                  StallReqFromEx,
    input  logic                  StallReqFromMem,
    input  logic                  LoadUseFromId,
    output logic                  HoldPc,
    output logic                  HoldIf2Id,
    output logic                  HoldId2Ex,
    output logic                  HoldEx2Mem,
    output logic                  FlushIf2Id,
    output logic                  FlushId2Ex,
    output logic                  JumpFlagToPc,
    output logic [ADDR_WIDTH-1:0] JumpAddrToPc
`ifdef PIPE_HOLD_CTRL_PERF_EN
    ,
    output logic [31:0]           StallCycleCnt,
    output logic [31:0]           RedirectCnt
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        EXWAIT  = 2'd2,
        FLUSH   = 2'd3
    } state_e;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_EXTRA);

    state_e                  state_q, state_d;
    logic                    pend_jump_q, pend_jump_d;
    logic [ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
    logic [2:0]              flush_cnt_q, flush_cnt_d;

    logic                    hold_pc, hold_if2id, hold_id2ex, hold_ex2mem;
    logic                    flush_if2id, flush_id2ex, jump_flag;
    logic [ADDR_WIDTH-1:0]   jump_addr;

    // NOTE: state registers use non-blocking assignments so that every
    // flop samples the values from before the edge.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= RUN;
            pend_jump_q <= 1'b0;
            pend_addr_q <= '0;
            flush_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            pend_jump_q <= pend_jump_d;
            pend_addr_q <= pend_addr_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // NOTE: every signal in this block gets a default first, so that no latch
    // is inferred on any branch.
    always_comb begin
        state_d     = state_q;
        pend_jump_d = pend_jump_q;
        pend_addr_d = pend_addr_q;
        flush_cnt_d = flush_cnt_q;
        hold_pc     = 1'b0;
        hold_if2id  = 1'b0;
        hold_id2ex  = 1'b0;
        hold_ex2mem = 1'b0;
        flush_if2id = 1'b0;
        flush_id2ex = 1'b0;
        jump_flag   = 1'b0;
        jump_addr   = '0;

        if (StallReqFromMem) begin
            hold_pc     = 1'b1;
            hold_if2id  = 1'b1;
            hold_id2ex  = 1'b1;
            hold_ex2mem = 1'b1;
            state_d     = MEMWAIT;
            // Keep only the first target. The held EX instruction keeps
            // re-raising the same jump until the stall releases.
            if (JumpFlagFromEx && !pend_jump_q) begin
                pend_jump_d = 1'b1;
                pend_addr_d = JumpAddrFromEx;
            end
        end else if (StallReqFromEx) begin
            hold_pc    = 1'b1;
            hold_if2id = 1'b1;
            hold_id2ex = 1'b1;
            state_d    = EXWAIT;
        end else if (pend_jump_q ||
                     (JumpFlagFromEx && (state_q == RUN || state_q == FLUSH))) begin
            // A pending jump has precedence over a new flag in the same cycle.
            jump_flag   = 1'b1;
            jump_addr   = pend_jump_q ? pend_addr_q : JumpAddrFromEx;
            flush_if2id = 1'b1;
            flush_id2ex = 1'b1;
            pend_jump_d = 1'b0;
            pend_addr_d = '0;
            flush_cnt_d = FLUSH_INIT;
            state_d     = (FLUSH_EXTRA > 0) ? FLUSH : RUN;
        end else if (flush_cnt_q != 3'd0) begin
            // A non-zero count means a flush sequence is active. A stall
            // only pauses the sequence, so it resumes after a wait state.
            flush_if2id = 1'b1;
            flush_cnt_d = flush_cnt_q - 3'd1;
            state_d     = (flush_cnt_q == 3'd1) ? RUN : FLUSH;
        end else begin
            state_d = RUN;
            if (LoadUseFromId) begin
                hold_pc     = 1'b1;
                hold_if2id  = 1'b1;
                flush_id2ex = 1'b1;
            end
        end
    end

    // Reset forces every output low at once, even if a stall or a flush
    // is being requested.
    assign HoldPc       = Rst & hold_pc;
    assign HoldIf2Id    = Rst & hold_if2id;
    assign HoldId2Ex    = Rst & hold_id2ex;
    assign HoldEx2Mem   = Rst & hold_ex2mem;
    assign FlushIf2Id   = Rst & flush_if2id;
    assign FlushId2Ex   = Rst & flush_id2ex;
    assign JumpFlagToPc = Rst & jump_flag;
    assign JumpAddrToPc = Rst ? jump_addr : '0;

`ifdef PIPE_HOLD_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] redirect_cnt_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_cnt_q    <= 32'd0;
            redirect_cnt_q <= 32'd0;
        end else begin
            if (HoldPc)       stall_cnt_q    <= stall_cnt_q + 32'd1;
            if (JumpFlagToPc) redirect_cnt_q <= redirect_cnt_q + 32'd1;
        end
    end

    assign StallCycleCnt = stall_cnt_q;
    assign RedirectCnt   = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hold_ctrl
//
// Directed testbench for pipe_hold_ctrl with ADDR_WIDTH=64 and FLUSH_EXTRA=1.
// Each scenario task drives one input vector per cycle and compares the outputs
// at the falling edge against hand-computed values.
//
// The outputs are compared as a packed vector, in this order:
//   {HoldPc, HoldIf2Id, HoldId2Ex, HoldEx2Mem, FlushIf2Id, FlushId2Ex, JumpFlagToPc}
//
// The input vector is packed as {mem, ex, lu, jf}.
// -----------------------------------------------------------------------------
module tb_pipe_hold_ctrl;

    localparam int AW = 64;

    logic          Clk;
    logic          Rst;
    logic          JumpFlagFromEx;
    logic [AW-1:0] JumpAddrFromEx;
    logic          StallReqFromEx;
    logic          StallReqFromMem;
    logic          LoadUseFromId;
    logic          HoldPc, HoldIf2Id, HoldId2Ex, HoldEx2Mem;
    logic          FlushIf2Id, FlushId2Ex, JumpFlagToPc;
    logic [AW-1:0] JumpAddrToPc;
`ifdef PIPE_HOLD_CTRL_PERF_EN
    logic [31:0]   StallCycleCnt;
    logic [31:0]   RedirectCnt;
`endif

    int total = 0;
    int bad   = 0;

    pipe_hold_ctrl #(.ADDR_WIDTH(AW), .FLUSH_EXTRA(1)) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .JumpFlagFromEx  (JumpFlagFromEx),
        .JumpAddrFromEx  (JumpAddrFromEx),
        .StallReqFromEx  (StallReqFromEx),
        .StallReqFromMem (StallReqFromMem),
        .LoadUseFromId   (LoadUseFromId),
        .HoldPc          (HoldPc),
        .HoldIf2Id       (HoldIf2Id),
        .HoldId2Ex       (HoldId2Ex),
        .HoldEx2Mem      (HoldEx2Mem),
        .FlushIf2Id      (FlushIf2Id),
        .FlushId2Ex      (FlushId2Ex),
        .JumpFlagToPc    (JumpFlagToPc),
        .JumpAddrToPc    (JumpAddrToPc)
`ifdef PIPE_HOLD_CTRL_PERF_EN
        ,
        .StallCycleCnt   (StallCycleCnt),
        .RedirectCnt     (RedirectCnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [6:0] outs();
        return {HoldPc, HoldIf2Id, HoldId2Ex, HoldEx2Mem,
                FlushIf2Id, FlushId2Ex, JumpFlagToPc};
    endfunction

    task automatic drive(input logic [3:0] st, input logic [AW-1:0] addr);
        {StallReqFromMem, StallReqFromEx, LoadUseFromId, JumpFlagFromEx} = st;
        JumpAddrFromEx = addr;
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        // Hold reset while requesting a stall and a jump. The outputs must
        // stay at 0.
        drive(4'b1001, 64'h8000_0000);
        @(negedge Clk);
        total++;
        if (outs() !== 7'b0 || JumpAddrToPc !== '0) begin
            bad++;
            $display("FAIL reset_outs: got %b/%h want 0000000/0", outs(), JumpAddrToPc);
        end
        drive(4'b0000, '0);
        next_cycle();
        Rst = 1'b1;
        @(negedge Clk);
        total++;
        if (outs() !== 7'b0 || JumpAddrToPc !== '0) begin
            bad++;
            $display("FAIL reset_release: got %b/%h want 0000000/0", outs(), JumpAddrToPc);
        end
        next_cycle();
    endtask

    task automatic test_jump_run();
        logic [3:0]    st [3] = '{4'b0001, 4'b0000, 4'b0000};
        logic [6:0]    ex [3] = '{7'b0000111, 7'b0000100, 7'b0000000};
        logic [AW-1:0] ea [3] = '{64'h8000_0100, 64'h0, 64'h0};
        for (int i = 0; i < 3; i++) begin
            drive(st[i], 64'h8000_0100);
            @(negedge Clk);
            total++;
            if (outs() !== ex[i] || JumpAddrToPc !== ea[i]) begin
                bad++;
                $display("FAIL jump_run[%0d]: got %b/%h want %b/%h", i, outs(), JumpAddrToPc, ex[i], ea[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_mem_stall();
        logic [3:0] st [4] = '{4'b1000, 4'b1000, 4'b1000, 4'b0000};
        logic [6:0] ex [4] = '{7'b1111000, 7'b1111000, 7'b1111000, 7'b0000000};
        for (int i = 0; i < 4; i++) begin
            drive(st[i], '0);
            @(negedge Clk);
            total++;
            if (outs() !== ex[i] || JumpAddrToPc !== '0) begin
                bad++;
                $display("FAIL mem_stall[%0d]: got %b/%h want %b/0", i, outs(), JumpAddrToPc, ex[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_mem_jump();
        // The jump is raised with the mem stall and held for 4 cycles. One
        // redirect follows, in the release cycle.
        logic [3:0]    st [7] = '{4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0000, 4'b0000, 4'b0000};
        logic [6:0]    ex [7] = '{7'b1111000, 7'b1111000, 7'b1111000, 7'b1111000,
                                  7'b0000111, 7'b0000100, 7'b0000000};
        logic [AW-1:0] ea [7] = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h8000_0200, 64'h0, 64'h0};
        for (int i = 0; i < 7; i++) begin
            // After the first cycle the EX address changes. The latched first
            // target must be the one replayed.
            drive(st[i], (i == 0) ? 64'h8000_0200 : 64'h0000_0BAD);
            @(negedge Clk);
            total++;
            if (outs() !== ex[i] || JumpAddrToPc !== ea[i]) begin
                bad++;
                $display("FAIL mem_jump[%0d]: got %b/%h want %b/%h", i, outs(), JumpAddrToPc, ex[i], ea[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_ex_stall();
        // Shows that HoldEx2Mem stays low for an EX stall. Also shows the
        // MEMWAIT -> EXWAIT transition when the mem stall drops first.
        logic [3:0] st [5] = '{4'b0100, 4'b1100, 4'b0100, 4'b0000, 4'b0000};
        logic [6:0] ex [5] = '{7'b1110000, 7'b1111000, 7'b1110000, 7'b0000000, 7'b0000000};
        for (int i = 0; i < 5; i++) begin
            drive(st[i], '0);
            @(negedge Clk);
            total++;
            if (outs() !== ex[i] || JumpAddrToPc !== '0) begin
                bad++;
                $display("FAIL ex_stall[%0d]: got %b/%h want %b/0", i, outs(), JumpAddrToPc, ex[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_load_use();
        // Load-use alone, then load-use together with a jump (the jump wins),
        // then load-use inside FLUSH (ignored).
        logic [3:0]    st [7] = '{4'b0010, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 4'b0010};
        logic [6:0]    ex [7] = '{7'b1100010, 7'b0000000, 7'b0000111, 7'b0000100,
                                  7'b0000000, 7'b1100010, 7'b1100010};
        logic [AW-1:0] ea [7] = '{64'h0, 64'h0, 64'h8000_0300, 64'h0, 64'h0, 64'h0, 64'h0};
        for (int i = 0; i < 7; i++) begin
            drive(st[i], 64'h8000_0300);
            @(negedge Clk);
            total++;
            if (outs() !== ex[i] || JumpAddrToPc !== ea[i]) begin
                bad++;
                $display("FAIL load_use[%0d]: got %b/%h want %b/%h", i, outs(), JumpAddrToPc, ex[i], ea[i]);
            end
            next_cycle();
        end
        // Load-use while FLUSH is active is ignored.
        drive(4'b0001, 64'h8000_0310);
        next_cycle();
        drive(4'b0010, '0);
        @(negedge Clk);
        total++;
        if (outs() !== 7'b0000100) begin
            bad++;
            $display("FAIL load_use_in_flush: got %b want 0000100", outs());
        end
        next_cycle();
        drive(4'b0000, '0);
        next_cycle();
    endtask

    task automatic test_flush_restart_pause();
        // A jump inside FLUSH reloads the count. A mem stall inside FLUSH
        // pauses the count.
        logic [3:0]    st [7] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b1000, 4'b0000, 4'b0000};
        logic [AW-1:0] sa [7] = '{64'h8000_0A00, 64'h8000_0B00, 64'h0, 64'h8000_0C00, 64'h0, 64'h0, 64'h0};
        logic [6:0]    ex [7] = '{7'b0000111, 7'b0000111, 7'b0000100, 7'b0000111,
                                  7'b1111000, 7'b0000100, 7'b0000000};
        logic [AW-1:0] ea [7] = '{64'h8000_0A00, 64'h8000_0B00, 64'h0, 64'h8000_0C00, 64'h0, 64'h0, 64'h0};
        for (int i = 0; i < 7; i++) begin
            drive(st[i], sa[i]);
            @(negedge Clk);
            total++;
            if (outs() !== ex[i] || JumpAddrToPc !== ea[i]) begin
                bad++;
                $display("FAIL flush_seq[%0d]: got %b/%h want %b/%h", i, outs(), JumpAddrToPc, ex[i], ea[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_stall();
        // Enter MEMWAIT with a pending jump, then assert reset away from the
        // clock edge.
        drive(4'b1001, 64'h8000_0400);
        next_cycle();
        drive(4'b1000, '0);
        #2;
        Rst = 1'b0;
        #1;
        total++;
        if (outs() !== 7'b0 || JumpAddrToPc !== '0) begin
            bad++;
            $display("FAIL reset_mid_outs: got %b/%h want 0000000/0", outs(), JumpAddrToPc);
        end
`ifdef PIPE_HOLD_CTRL_PERF_EN
        total++;
        if (StallCycleCnt !== 32'd0 || RedirectCnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid_cnt: got %0d/%0d want 0/0", StallCycleCnt, RedirectCnt);
        end
`endif
        next_cycle();
        drive(4'b0000, '0);
        Rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            total++;
            if (outs() !== 7'b0 || JumpAddrToPc !== '0) begin
                bad++;
                $display("FAIL reset_mid_after[%0d]: got %b/%h want 0000000/0", i, outs(), JumpAddrToPc);
            end
            next_cycle();
        end
    endtask

    initial begin
        Rst = 1'b0;
        drive(4'b0000, '0);
        #2;
        test_reset();
        test_jump_run();
        test_mem_stall();
        test_mem_jump();
        test_ex_stall();
        test_load_use();
        test_flush_restart_pause();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hold_ctrl.md
Name: pipe_hold_ctrl

Overview:
- Pipeline control unit that drives the hold/flush side of every inter-stage register (PC, IF/ID, ID/EX, EX/MEM). It is the producer of the hold flag the stage registers consume.
- Arbitrates EX jump redirects, multi-cycle EX stalls, memory wait stalls and ID load-use hazards.
- Issues a single PC redirect and inserts bubbles, with a small FSM that remembers jumps raised during a stall.

Parameters:
- ADDR_WIDTH, 64, width of jump target address.
- FLUSH_EXTRA, 1, extra cycles (0..7) IF/ID stays flushed after a redirect, covering fetch latency.

Ports:
- Clk  input  1  clock.
- Rst  input  1  asynchronous active-low reset.
- JumpFlagFromEx  input  1  EX resolved a taken branch/jump this cycle.
- JumpAddrFromEx  input  ADDR_WIDTH  redirect target.
- StallReqFromEx  input  1  multi-cycle EX op busy.
- StallReqFromMem  input  1  data memory not ready.
- LoadUseFromId  input  1  ID source matches a load in EX.
- HoldPc  output  1  1 = PC keeps value.
- HoldIf2Id  output  1  1 = IF/ID register frozen.
- HoldId2Ex  output  1  1 = ID/EX register frozen.
- HoldEx2Mem  output  1  1 = EX/MEM register frozen.
- FlushIf2Id  output  1  1 = IF/ID loads NOP/zero at next edge.
- FlushId2Ex  output  1  1 = ID/EX loads NOP/zero at next edge.
- JumpFlagToPc  output  1  one-cycle redirect strobe.
- JumpAddrToPc  output  ADDR_WIDTH  redirect target, valid while JumpFlagToPc=1.

Behaviour:
- Reset (Rst=0, async): state RUN, PendJump=0, PendAddr=0, FlushCnt=0. All outputs 0 immediately, including mid-stall or mid-flush.
- Outputs are combinational from state plus the current inputs, so they act in the same cycle. State and pending registers update on the Clk rising edge.
- States: RUN, MEMWAIT, EXWAIT, FLUSH.
- Priority each cycle: StallReqFromMem > StallReqFromEx > jump (pending or new) > LoadUseFromId.
- Mem stall (any state): all four holds = 1, no flushes, JumpFlagToPc = 0. Next state MEMWAIT.
- Jump during a mem stall: if JumpFlagFromEx=1 and PendJump=0, latch PendAddr = JumpAddrFromEx and set PendJump=1. Later JumpFlagFromEx pulses are ignored while PendJump=1, because the held EX instruction re-asserts.
- EX stall (no mem stall): HoldPc, HoldIf2Id, HoldId2Ex = 1. HoldEx2Mem = 0. Next state EXWAIT.
- Jump accepted (no stall):
  - Fires if PendJump=1, or JumpFlagFromEx=1 in RUN/FLUSH.
  - JumpFlagToPc = 1. JumpAddrToPc = PendAddr if PendJump=1, else JumpAddrFromEx.
  - FlushIf2Id = FlushId2Ex = 1. All holds = 0.
  - PendJump cleared. FlushCnt = FLUSH_EXTRA. Next state FLUSH if FLUSH_EXTRA>0, else RUN.
- Stall release: if PendJump=1, the redirect occurs in the first cycle both stall requests are 0. JumpFlagFromEx in that same cycle is ignored.
- FLUSH: FlushIf2Id = 1 and FlushCnt decrements each cycle. Exit to RUN when FlushCnt reaches 1→0.
  - A new jump in FLUSH restarts the sequence (reload FlushCnt).
  - A stall in FLUSH pauses FlushCnt.
- Load-use (RUN, nothing higher): HoldPc = HoldIf2Id = 1, FlushId2Ex = 1, for one cycle per asserted cycle. State stays RUN. Ignored in FLUSH, where IF/ID is already a bubble.
- MEMWAIT/EXWAIT return to RUN, or fire the pending jump, when their request drops. MEMWAIT→EXWAIT is allowed when the mem stall drops while the EX stall persists.
- JumpAddrToPc = 0 whenever JumpFlagToPc = 0.

Optional Feature:
- Macro PIPE_HOLD_CTRL_PERF_EN.
- Defined: adds output ports StallCycleCnt[31:0] and RedirectCnt[31:0].
  - StallCycleCnt increments every cycle HoldPc=1.
  - RedirectCnt increments every cycle JumpFlagToPc=1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Jump in RUN, JumpAddrFromEx=0x80000100, FLUSH_EXTRA=1 → cycle 0: JumpFlagToPc=1, JumpAddrToPc=0x80000100, FlushIf2Id=FlushId2Ex=1. Cycle 1: FlushIf2Id=1 only. Cycle 2: all 0.
- StallReqFromMem=1 for 3 cycles → four holds =1 for exactly those 3 cycles, 0 on the 4th; no flush.
- StallReqFromMem=1 while JumpFlagFromEx=1 with 0x80000200 held for 4 cycles → no redirect during the stall; exactly one JumpFlagToPc pulse with 0x80000200 in the release cycle.
- LoadUseFromId=1 and JumpFlagFromEx=1 in the same cycle → jump wins: JumpFlagToPc=1, HoldPc=0, FlushId2Ex=1.
- LoadUseFromId=1 alone for 1 cycle → HoldPc=HoldIf2Id=1, FlushId2Ex=1, HoldId2Ex=0, then all 0.
- Rst low mid-MEMWAIT with PendJump=1, then high → outputs 0 immediately; no redirect after release. With PIPE_HOLD_CTRL_PERF_EN, counters read 0.
